// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - RV32I hazard/flow controller: stalls, flushes, forwarding selects, memory wait watchdog
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_rf_wr_enable_i,
    input  logic             ex_is_load_i,
    input  logic             pc_select_src_i,
    input  logic             mem_valid_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic             mem_rf_wr_enable_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_wb_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [1:0]        rs1_sel_q, rs1_sel_d;
    logic [1:0]        rs2_sel_q, rs2_sel_d;

    logic mem_stall;
    logic ctrl_flush;
    logic lu;
    logic lu_rs1_hit;
    logic lu_rs2_hit;
    logic [1:0] rs1_fwd;
    logic [1:0] rs2_fwd;

    assign mem_stall  = mem_req_i & ~mem_ack_i;
    assign ctrl_flush = pc_select_src_i & ex_valid_i & ~mem_stall;

    assign lu_rs1_hit = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
    assign lu_rs2_hit = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);
    assign lu = ex_valid_i & ex_is_load_i & ex_rf_wr_enable_i & (ex_rd_addr_i != 5'd0)
              & id_valid_i & (lu_rs1_hit | lu_rs2_hit) & ~mem_stall & ~ctrl_flush;

    // The EX producer moves to MEM as the consumer enters EX, so an EX hit selects EX/MEM.
    always_comb begin
        rs1_fwd = 2'd0;
        rs2_fwd = 2'd0;
        if (id_uses_rs1_i && id_rs1_addr_i != 5'd0) begin
            if (ex_valid_i && ex_rf_wr_enable_i && ex_rd_addr_i == id_rs1_addr_i)
                rs1_fwd = 2'd1;
            else if (mem_valid_i && mem_rf_wr_enable_i && mem_rd_addr_i == id_rs1_addr_i)
                rs1_fwd = 2'd2;
        end
        if (id_uses_rs2_i && id_rs2_addr_i != 5'd0) begin
            if (ex_valid_i && ex_rf_wr_enable_i && ex_rd_addr_i == id_rs2_addr_i)
                rs2_fwd = 2'd1;
            else if (mem_valid_i && mem_rf_wr_enable_i && mem_rd_addr_i == id_rs2_addr_i)
                rs2_fwd = 2'd2;
        end
    end

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        flush_wb_o  = 1'b0;
        if (rst_i) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
            flush_wb_o = 1'b1;
        end else if (mem_stall) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            stall_mem_o = 1'b1;
            flush_wb_o  = 1'b1;
        end else if (ctrl_flush) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else if (lu) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        rs1_sel_d   = rs1_sel_q;
        rs2_sel_d   = rs2_sel_q;

        case (state_q)
            RUN:      if (mem_stall) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ack_i) state_d = RUN;
            default:  state_d = RUN;
        endcase

        // Counts every cycle that ends in MEM_WAIT, including the entry cycle; saturates.
        if (state_d == MEM_WAIT) begin
            if (wait_cnt_q >= WC_W'(MEM_TIMEOUT - 1))
                timeout_d = 1'b1;
            if (wait_cnt_q != WC_W'(MEM_TIMEOUT))
                wait_cnt_d = wait_cnt_q + WC_W'(1);
        end else begin
            wait_cnt_d = '0;
        end

        if (stall_if_o) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ctrl_flush) flush_cnt_d = flush_cnt_q + CNT_W'(1);

        if (flush_ex_o) begin
            rs1_sel_d = 2'd0;
            rs2_sel_d = 2'd0;
        end else if (!stall_ex_o && !stall_id_o) begin
            rs1_sel_d = rs1_fwd;
            rs2_sel_d = rs2_fwd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            rs1_sel_q   <= 2'd0;
            rs2_sel_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            rs1_sel_q   <= rs1_sel_d;
            rs2_sel_q   <= rs2_sel_d;
        end
    end

    assign fwd_rs1_sel_o = rs1_sel_q;
    assign fwd_rs2_sel_o = rs2_sel_q;
    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
